// File: rtl/hatch_pkg.sv
// Shared definitions for the hatch incubator sequencer.
//   - FSM state encoding used by hatch_stage_ctrl.
//   - Stage count and default incubation temperature window.
//   - in_window(): unsigned 8-bit inclusive window compare.
package hatch_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int NUM_STAGES  = 12;
    localparam int TEMP_LO_DEF = 37;
    localparam int TEMP_HI_DEF = 39;

    function automatic logic in_window(input logic [7:0] t,
                                       input logic [7:0] lo,
                                       input logic [7:0] hi);
        return (t >= lo) && (t <= hi);
    endfunction

endpackage

// File: rtl/hatch_stage_ctrl_key_pulse.sv
// Panel key conditioner: 2-flop synchronizer, level debounce and a single
// 1-cycle pulse on each accepted press. Reusable for any panel key.
// Ports:
//   clk    in  system clock
//   rst    in  asynchronous active-low reset
//   key    in  raw push-button, active-high, asynchronous to clk
//   press  out 1-cycle pulse when a debounced 0->1 transition is accepted
module key_pulse #(
    parameter int DEB_CYC = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press
);
    import hatch_pkg::*;

    localparam int CW = $clog2(DEB_CYC + 1);

    logic          key_p0;
    logic          key_p1;
    logic          key_lvl;
    logic [CW-1:0] deb_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_p0  <= 1'b0;
            key_p1  <= 1'b0;
            key_lvl <= 1'b0;
            deb_cnt <= '0;
            press   <= 1'b0;
        end else begin
            key_p0 <= key;
            key_p1 <= key_p0;
            press  <= 1'b0;
            // Count consecutive cycles where the synchronized key differs
            // from the accepted level; any agreeing sample restarts the run.
            if (key_p1 != key_lvl) begin
                if (deb_cnt == CW'(DEB_CYC - 1)) begin
                    key_lvl <= key_p1;
                    deb_cnt <= '0;
                    press   <= key_p1;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/hatch_stage_ctrl.sv
// Egg-incubation sequencer feeding the dot-matrix display stage.
// Steps a stage index through the hatch timeline on a start/stop key and
// freezes progress while the incubator temperature is out of window.
// Ports:
//   clk        in   system clock (1 kHz)
//   rst        in   asynchronous active-low reset
//   key_start  in   raw start/stop push-button, active-high
//   temp_c     in   incubator temperature, unsigned degC
//   num        out  current stage index 0..LAST_STAGE
//   st         out  display enable, high in RUN, PAUSE and DONE
//   temp       out  filtered temperature fault (1 = out of window)
//   done       out  high while in DONE
module hatch_stage_ctrl
    import hatch_pkg::*;
#(
    parameter int TICKS_PER_STAGE = 3000,
    parameter int LAST_STAGE      = NUM_STAGES - 1,
    parameter int TEMP_LO         = TEMP_LO_DEF,
    parameter int TEMP_HI         = TEMP_HI_DEF,
    parameter int FILT_CYC        = 16,
    parameter int DEB_CYC         = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_start,
    input  logic [7:0] temp_c,
    output logic [3:0] num,
    output logic       st,
    output logic       temp,
    output logic       done
);

    localparam int TW = $clog2(TICKS_PER_STAGE);
    localparam int FW = $clog2(FILT_CYC + 1);

    logic          press;
    logic          inwin;
    logic [FW-1:0] filt_cnt;
    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nx;
    logic [3:0]    num_nx;

    key_pulse #(
        .DEB_CYC (DEB_CYC)
    ) u_key_start (
        .clk   (clk),
        .rst   (rst),
        .key   (key_start),
        .press (press)
    );

    assign inwin = in_window(temp_c, 8'(TEMP_LO), 8'(TEMP_HI));

    // Temperature fault filter: a sample disagreeing with the current flag
    // (out of window while temp=0, in window while temp=1) extends the run;
    // an agreeing sample restarts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            temp     <= 1'b0;
            filt_cnt <= '0;
        end else if (inwin == temp) begin
            if (filt_cnt == FW'(FILT_CYC - 1)) begin
                temp     <= ~temp;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end else begin
            filt_cnt <= '0;
        end
    end

    // Next-state logic. press is checked first in every state so that an
    // abort wins over a same-cycle rollover or temperature change.
    always_comb begin
        state_nx = state;
        timer_nx = timer;
        num_nx   = num;
        case (state)
            ST_IDLE: begin
                timer_nx = '0;
                num_nx   = '0;
                if (press) state_nx = temp ? ST_PAUSE : ST_RUN;
            end
            ST_RUN: begin
                if (press) begin
                    state_nx = ST_IDLE;
                    timer_nx = '0;
                    num_nx   = '0;
                end else if (timer == TW'(TICKS_PER_STAGE - 1)) begin
                    // Stage advances even if a fault arrives this cycle;
                    // the pause then starts from the new stage.
                    timer_nx = '0;
                    num_nx   = num + 4'd1;
                    if (num_nx == 4'(LAST_STAGE)) state_nx = ST_DONE;
                    else if (temp)                state_nx = ST_PAUSE;
                end else if (temp) begin
                    state_nx = ST_PAUSE;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            ST_PAUSE: begin
                if (press) begin
                    state_nx = ST_IDLE;
                    timer_nx = '0;
                    num_nx   = '0;
                end else if (!temp) begin
                    state_nx = ST_RUN;
                end
            end
            ST_DONE: begin
                timer_nx = '0;
                num_nx   = 4'(LAST_STAGE);
                if (press) begin
                    state_nx = ST_IDLE;
                    num_nx   = '0;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                timer_nx = '0;
                num_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            timer <= '0;
            num   <= '0;
            st    <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            timer <= timer_nx;
            num   <= num_nx;
            st    <= (state_nx != ST_IDLE);
            done  <= (state_nx == ST_DONE);
        end
    end

endmodule

// File: tb/tb_hatch_stage_ctrl.sv
module tb_hatch_stage_ctrl;

    localparam int TPS  = 3000;
    localparam int LAST = 11;
    localparam int FILT = 16;
    localparam int DEB  = 20;

    logic       clk       = 1'b0;
    logic       rst       = 1'b0;
    logic       key_start = 1'b0;
    logic [7:0] temp_c    = 8'd38;
    logic [3:0] num;
    logic       st;
    logic       temp;
    logic       done;

    hatch_stage_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .key_start (key_start),
        .temp_c    (temp_c),
        .num       (num),
        .st        (st),
        .temp      (temp),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0] num;
        int         cyc;   // -1: cycle not checked
    } ev_t;
    ev_t exp_q[$];

    bit         mon_en   = 1'b0;
    logic [3:0] num_prev = 4'd0;

    // Scoreboard: every change of num is popped against the expectation queue.
    always @(negedge clk) begin : mon
        ev_t e;
        if (mon_en && num !== num_prev) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL num_event: got num=%0d at cycle %0d, required no change", num, cyc);
            end else begin
                e = exp_q.pop_front();
                if (num !== e.num || (e.cyc >= 0 && cyc != e.cyc)) begin
                    fails++;
                    $display("FAIL num_event: got num=%0d at cycle %0d, required num=%0d at cycle %0d",
                             num, cyc, e.num, e.cyc);
                end
            end
        end
        num_prev <= num;
    end

    task automatic wait_st(input logic val, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (st === val) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_temp(input logic val, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (temp === val) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_num(input logic [3:0] val, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (num === val) begin ok = 1'b1; break; end
        end
    endtask

    // Press the key until st reaches val (bounded), then release.
    task automatic key_until_st(input logic val, output bit ok, output int at);
        key_start = 1'b1;
        wait_st(val, DEB + 3, ok);
        at = cyc;
        key_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (4) @(negedge clk);
        tests++; if (num !== 4'd0)  begin fails++; $display("FAIL reset_num: got %0d, required 0", num); end
        tests++; if (st !== 1'b0)   begin fails++; $display("FAIL reset_st: got %b, required 0", st); end
        tests++; if (temp !== 1'b0) begin fails++; $display("FAIL reset_temp: got %b, required 0", temp); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b, required 0", done); end
        rst = 1'b1;
        repeat (10) @(negedge clk);
        tests++; if (st !== 1'b0 || num !== 4'd0) begin
            fails++; $display("FAIL reset_release: got st=%b num=%0d, required st=0 num=0", st, num);
        end
    endtask

    task automatic test_bounce();
        bit bad = 1'b0;
        bit ok;
        int at;
        int rises = 0;
        logic st_q;
        for (int p = 0; p < 8; p++) begin
            key_start = 1'b1;
            repeat (5) begin @(negedge clk); if (st !== 1'b0) bad = 1'b1; end
            key_start = 1'b0;
            repeat (5) begin @(negedge clk); if (st !== 1'b0) bad = 1'b1; end
        end
        repeat (30) begin @(negedge clk); if (st !== 1'b0) bad = 1'b1; end
        tests++; if (bad) begin fails++; $display("FAIL bounce_press: got st=1 from bouncing key, required st=0"); end
        // Held key: exactly one press, so st rises once and never falls.
        key_start = 1'b1;
        st_q = st;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (st === 1'b1 && st_q !== 1'b1) rises++;
            if (st === 1'b0 && st_q === 1'b1) rises += 10;
            st_q = st;
        end
        key_start = 1'b0;
        repeat (40) @(negedge clk);
        tests++; if (rises != 1 || st !== 1'b1) begin
            fails++; $display("FAIL held_key: got %0d st edges (weighted) st=%b, required 1 rise st=1", rises, st);
        end
        exp_q.push_back('{num: 4'd0, cyc: -1});
        key_until_st(1'b0, ok, at);
        tests++; if (!ok) begin fails++; $display("FAIL held_abort: got st=%b, required 0 within %0d cycles", st, DEB + 3); end
        repeat (30) @(negedge clk);
        exp_q.delete();
    endtask

    task automatic test_press_idle_hot();
        bit ok;
        int at;
        temp_c = 8'd45;
        repeat (20) @(negedge clk);
        tests++; if (temp !== 1'b1) begin fails++; $display("FAIL hot_idle_temp: got %b, required 1", temp); end
        key_until_st(1'b1, ok, at);
        tests++; if (!ok) begin fails++; $display("FAIL hot_press_st: got st=%b, required 1 within %0d cycles", st, DEB + 3); end
        repeat (200) @(negedge clk);
        tests++; if (num !== 4'd0 || st !== 1'b1 || done !== 1'b0) begin
            fails++; $display("FAIL hot_pause_hold: got num=%0d st=%b done=%b, required 0/1/0", num, st, done);
        end
        key_until_st(1'b0, ok, at);
        tests++; if (!ok) begin fails++; $display("FAIL hot_abort: got st=%b, required 0", st); end
        temp_c = 8'd38;
        repeat (30) @(negedge clk);
        tests++; if (temp !== 1'b0) begin fails++; $display("FAIL hot_recover: got temp=%b, required 0", temp); end
    endtask

    task automatic test_run_to_done();
        bit ok;
        int sc;
        temp_c = 8'd38;
        key_until_st(1'b1, ok, sc);
        tests++; if (!ok) begin fails++; $display("FAIL start_st: got st=%b, required 1 within %0d cycles", st, DEB + 3); end
        for (int k = 1; k <= LAST; k++) exp_q.push_back('{num: 4'(k), cyc: sc + k * TPS});
        wait_num(4'(LAST), LAST * TPS + 10, ok);
        tests++; if (!ok || done !== 1'b1 || st !== 1'b1) begin
            fails++; $display("FAIL done_reach: got num=%0d done=%b st=%b, required %0d/1/1", num, done, st, LAST);
        end
        // Temperature faults do not disturb DONE.
        temp_c = 8'd45;
        repeat (40) @(negedge clk);
        tests++; if (temp !== 1'b1 || done !== 1'b1 || num !== 4'(LAST)) begin
            fails++; $display("FAIL done_hot: got temp=%b done=%b num=%0d, required 1/1/%0d", temp, done, num, LAST);
        end
        temp_c = 8'd38;
        repeat (40) @(negedge clk);
        exp_q.push_back('{num: 4'd0, cyc: -1});
        key_until_st(1'b0, ok, sc);
        tests++; if (!ok || done !== 1'b0 || num !== 4'd0) begin
            fails++; $display("FAIL done_press: got st=%b done=%b num=%0d, required 0/0/0", st, done, num);
        end
        repeat (30) @(negedge clk);
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL done_queue: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_temp_filter();
        bit ok;
        bit bad = 1'b0;
        int sc, c0, rise, fall;
        key_until_st(1'b1, ok, sc);
        tests++; if (!ok) begin fails++; $display("FAIL filt_start: got st=%b, required 1", st); end
        // Glitchy temperature shorter than the filter window never faults.
        for (int b = 0; b < 10; b++) begin
            temp_c = (b % 2 == 0) ? 8'd45 : 8'd38;
            repeat (8) begin @(negedge clk); if (temp !== 1'b0) bad = 1'b1; end
        end
        temp_c = 8'd38;
        tests++; if (bad) begin fails++; $display("FAIL glitch_temp: got temp=1, required 0"); end
        while (cyc < sc + 1000) @(negedge clk);
        temp_c = 8'd45;
        c0 = cyc;
        wait_temp(1'b1, FILT + 4, ok);
        rise = cyc;
        tests++; if (!ok || rise - c0 != FILT) begin
            fails++; $display("FAIL temp_rise: got %0d cycles, required %0d", rise - c0, FILT);
        end
        repeat (300) @(negedge clk);
        tests++; if (num !== 4'd0 || st !== 1'b1) begin
            fails++; $display("FAIL pause_hold: got num=%0d st=%b, required 0/1", num, st);
        end
        temp_c = 8'd38;
        c0 = cyc;
        wait_temp(1'b0, FILT + 4, ok);
        fall = cyc;
        tests++; if (!ok || fall - c0 != FILT) begin
            fails++; $display("FAIL temp_fall: got %0d cycles, required %0d", fall - c0, FILT);
        end
        // Frozen edges: from the one after temp rose through the one after it fell.
        exp_q.push_back('{num: 4'd1, cyc: sc + TPS + (fall - rise + 1)});
        wait_num(4'd1, TPS, ok);
        tests++; if (!ok) begin fails++; $display("FAIL resume_stage: got num=%0d, required 1", num); end
        exp_q.push_back('{num: 4'd0, cyc: -1});
        key_until_st(1'b0, ok, c0);
        tests++; if (!ok) begin fails++; $display("FAIL filt_abort: got st=%b, required 0", st); end
        repeat (30) @(negedge clk);
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL filt_queue: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_abort_run7();
        bit ok;
        int sc, c0;
        key_until_st(1'b1, ok, sc);
        tests++; if (!ok) begin fails++; $display("FAIL abort_start: got st=%b, required 1", st); end
        for (int k = 1; k <= 7; k++) exp_q.push_back('{num: 4'(k), cyc: sc + k * TPS});
        wait_num(4'd7, 7 * TPS + 10, ok);
        tests++; if (!ok) begin fails++; $display("FAIL reach7: got num=%0d, required 7", num); end
        repeat (100) @(negedge clk);
        exp_q.push_back('{num: 4'd0, cyc: -1});
        key_until_st(1'b0, ok, c0);
        tests++; if (!ok || num !== 4'd0 || done !== 1'b0) begin
            fails++; $display("FAIL abort7: got st=%b num=%0d, required st=0 num=0", st, num);
        end
        repeat (30) @(negedge clk);
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL abort_queue: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_reset_midrun();
        bit ok;
        bit bad = 1'b0;
        int sc;
        mon_en = 1'b0;
        exp_q.delete();
        key_until_st(1'b1, ok, sc);
        while (cyc < sc + 5 * TPS + 10) @(negedge clk);
        tests++; if (num !== 4'd5 || st !== 1'b1) begin
            fails++; $display("FAIL mid_num5: got num=%0d st=%b, required 5/1", num, st);
        end
        temp_c = 8'd45;
        repeat (20) @(negedge clk);
        tests++; if (temp !== 1'b1) begin fails++; $display("FAIL mid_temp: got %b, required 1", temp); end
        // Assert reset between clock edges: outputs must clear without a clock.
        #2 rst = 1'b0;
        #1;
        tests++; if (num !== 4'd0 || st !== 1'b0 || temp !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL async_reset: got num=%0d st=%b temp=%b done=%b, required 0/0/0/0", num, st, temp, done);
        end
        temp_c = 8'd38;
        @(negedge clk);
        rst = 1'b1;
        repeat (100) begin @(negedge clk); if (st !== 1'b0 || num !== 4'd0) bad = 1'b1; end
        tests++; if (bad) begin fails++; $display("FAIL post_reset_idle: got st=%b num=%0d, required 0/0", st, num); end
    endtask

    initial begin
        test_reset();
        mon_en = 1'b1;
        test_bounce();
        test_press_idle_hot();
        test_run_to_done();
        test_temp_filter();
        test_abort_run7();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
